reg_file_scoreboard: RTL

Parametrised successor to the core integer register file. It generalises width, depth and read-port count, and adds three things:
- an optional write-to-read bypass;
- a per-register busy scoreboard that tracks in-flight producers;
- a registered pending-producer count.
It sits between decode (read and issue side) and writeback (write side) in the pipeline.

---
 rtl/reg_file_scoreboard.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_file_scoreboard.sv
// Parametrised register file with optional write-to-read bypass, per-register busy scoreboard
// and registered pending-producer count. Define ZERO_REG_EN to hard-wire register 0 to zero.
module reg_file_scoreboard #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rdAddr,
    output logic [NUM_RD*REG_WIDTH-1:0]    rdData,
    output logic [NUM_RD-1:0]              rdBusy,
    input  logic                           wrEna,
    input  logic [ADDR_WIDTH-1:0]          wrAddr,
    input  logic [REG_WIDTH-1:0]           wrData,
    input  logic                           issueEna,
    input  logic [ADDR_WIDTH-1:0]          issueAddr,
    output logic                           issueReady,
    output logic [ADDR_WIDTH:0]            pendCount
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    if (DEPTH > 2**ADDR_WIDTH || DEPTH < 2) begin : g_bad_depth
        $error("reg_file_scoreboard: DEPTH must lie in 2..2**ADDR_WIDTH");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("reg_file_scoreboard: NUM_RD must lie in 1..4");
    end

    logic [REG_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 wr_ok;
    logic                 issue_set;
    logic                 wr_dec;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a);
    endfunction

    // Write qualification, issue acceptance and scoreboard next state
    always_comb begin
        wr_ok      = wrEna && in_range(wrAddr) && !is_zero(wrAddr);
        issueReady = in_range(issueAddr) && (is_zero(issueAddr) || !busy[idx(issueAddr)]);
        issue_set  = issueEna && issueReady && !is_zero(issueAddr);
        // An accepted issue needs a free bit, so a same-address clear never decrements here
        wr_dec     = wr_ok && busy[idx(wrAddr)];

        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[idx(wrAddr)] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[idx(issueAddr)] = 1'b1;
        end
        cnt_nxt = pendCount + CNT_W'(issue_set) - CNT_W'(wr_dec);
    end

    // Independent combinational read ports
    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic [REG_WIDTH-1:0]  d;
        logic                  b;

        assign a = rdAddr[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            d = '0;
            b = 1'b0;
            if (in_range(a) && !is_zero(a)) begin
                if (BYPASS != 0 && wr_ok && wrAddr == a) begin
                    d = wrData;
                end else begin
                    d = regs[idx(a)];
                    b = busy[idx(a)];
                end
            end
        end

        assign rdData[g*REG_WIDTH +: REG_WIDTH] = d;
        assign rdBusy[g]                        = b;
    end

    // Storage, busy bits and pending count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            pendCount <= '0;
        end else begin
            if (wr_ok) begin
                regs[idx(wrAddr)] <= wrData;
            end
            busy      <= busy_nxt;
            pendCount <= cnt_nxt;
        end
    end

endmodule
